// File: rtl/adc_serial_rx.sv
// Serial ADC capture: frames one conversion per sclk burst, shifts in MSB first,
// and presents the low data bits with a one-cycle valid strobe.
module adc_serial_rx #(
    parameter int FRAME_BITS   = 16,
    parameter int DATA_BITS    = 12,
    parameter int QUIET_CYCLES = 2
) (
    input  logic                 clk_in,
    input  logic                 clk_rst,
    input  logic                 sclk_in,
    input  logic                 enable,
    input  logic                 sdata_in,
    output logic                 cs_n,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_MAX = (FRAME_BITS > QUIET_CYCLES) ? FRAME_BITS : QUIET_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] LAST_BIT   = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] LAST_QUIET = CW'(QUIET_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, QUIET} state_t;

    state_t                 state_reg,  state_next;
    logic [CW-1:0]          cnt_reg,    cnt_next;
    logic [FRAME_BITS-1:0]  shreg_reg,  shreg_next;
    logic [DATA_BITS-1:0]   sample_reg, sample_next;
    logic                   cs_n_reg,   cs_n_next;
    logic                   valid_reg,  valid_next;
    logic                   err_reg,    err_next;
    logic                   sclk_d;
    logic                   rise, fall;

    // sclk_in is a register output in this domain, so a single delay stage suffices.
    assign rise = sclk_in & ~sclk_d;
    assign fall = ~sclk_in & sclk_d;

    always_ff @(posedge clk_in or posedge clk_rst) begin
        if (clk_rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            shreg_reg  <= '0;
            sample_reg <= '0;
            cs_n_reg   <= 1'b1;
            valid_reg  <= 1'b0;
            err_reg    <= 1'b0;
            sclk_d     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            shreg_reg  <= shreg_next;
            sample_reg <= sample_next;
            cs_n_reg   <= cs_n_next;
            valid_reg  <= valid_next;
            err_reg    <= err_next;
            sclk_d     <= sclk_in;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        shreg_next  = shreg_reg;
        sample_next = sample_reg;
        cs_n_next   = cs_n_reg;
        valid_next  = 1'b0;
        err_next    = err_reg;
        case (state_reg)
            IDLE: begin
                if (enable && fall) begin
                    cs_n_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // enable is deliberately ignored here so a started frame always completes
                if (rise) begin
                    shreg_next = {shreg_reg[FRAME_BITS-2:0], sdata_in};
                    cnt_next   = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                sample_next = shreg_reg[DATA_BITS-1:0];
                err_next    = |shreg_reg[FRAME_BITS-1:DATA_BITS];
                valid_next  = 1'b1;
                cs_n_next   = 1'b1;
                cnt_next    = '0;
                state_next  = QUIET;
            end
            QUIET: begin
                if (fall) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_QUIET) begin
                        if (enable) begin
                            cs_n_next  = 1'b0;
                            cnt_next   = '0;
                            state_next = SHIFT;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cs_n         = cs_n_reg;
    assign sample       = sample_reg;
    assign sample_valid = valid_reg;
    assign frame_err    = err_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_adc_serial_rx.sv
// Directed bench for adc_serial_rx with a behavioural ADC and a 71-cycle sclk half-period.
module tb_adc_serial_rx;

    localparam int H = 71;

    logic        clk_in = 1'b0;
    logic        clk_rst = 1'b1;
    logic        sclk_in = 1'b0;
    logic        enable = 1'b0;
    logic        sdata_in = 1'b0;
    logic        cs_n;
    logic [11:0] sample;
    logic        sample_valid;
    logic        frame_err;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    adc_serial_rx dut (
        .clk_in       (clk_in),
        .clk_rst      (clk_rst),
        .sclk_in      (sclk_in),
        .enable       (enable),
        .sdata_in     (sdata_in),
        .cs_n         (cs_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk_in = ~clk_in;

    // Divided serial clock: toggles just after a clk_in edge, like a register output.
    initial begin
        forever begin
            repeat (H) @(posedge clk_in);
            #1 sclk_in = ~sclk_in;
        end
    end

    // ADC model: MSB on cs_n falling, next bit after each sclk fall while selected.
    logic [15:0] adc_next = 16'h0000;
    logic [15:0] adc_cur  = 16'h0000;
    int          bit_idx  = 0;
    logic        adc_cs_prev   = 1'b1;
    logic        adc_sclk_prev = 1'b0;
    initial begin
        forever begin
            @(posedge clk_in);
            #2;
            if (adc_cs_prev && !cs_n) begin
                adc_cur  = adc_next;
                bit_idx  = 0;
                sdata_in = adc_cur[15];
            end else if (!cs_n && adc_sclk_prev && !sclk_in) begin
                bit_idx = bit_idx + 1;
                if (bit_idx < 16) sdata_in = adc_cur[15 - bit_idx];
            end
            adc_cs_prev   = cs_n;
            adc_sclk_prev = sclk_in;
        end
    end

    // Monitor: valid-cycle count, cs_n fall time, and length of the last cs_n-high gap.
    int   cyc = 0;
    int   valid_cnt = 0;
    int   fall_cyc = 0;
    int   high_run = 0;
    int   fall_run = 0;
    int   last_high = 0;
    int   last_falls = 0;
    logic mon_cs = 1'b1;
    logic mon_sclk = 1'b0;
    initial begin
        forever begin
            @(negedge clk_in);
            cyc = cyc + 1;
            if (sample_valid) valid_cnt = valid_cnt + 1;
            if (cs_n) begin
                high_run = high_run + 1;
                if (mon_sclk && !sclk_in) fall_run = fall_run + 1;
            end else begin
                if (mon_cs) begin
                    fall_cyc   = cyc;
                    last_high  = high_run;
                    last_falls = fall_run;
                end
                high_run = 0;
                fall_run = 0;
            end
            mon_cs   = cs_n;
            mon_sclk = sclk_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, output int latency);
        bit got;
        got = 1'b0;
        latency = -1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk_in);
            if (sample_valid) got = 1'b1;
        end
        #1;
        if (got) latency = cyc - fall_cyc;
        check({tag, "_timeout"}, {31'd0, got}, 32'd1);
    endtask

    task automatic wait_cs_fall(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk_in);
            if (!cs_n) got = 1'b1;
        end
        #1;
        check({tag, "_timeout"}, {31'd0, got}, 32'd1);
    endtask

    int lat;
    int vc;

    initial begin
        // 1: reset behaviour with sclk running, enable low
        repeat (3) @(negedge clk_in);
        #1;
        check("rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sample", {20'd0, sample}, 32'd0);
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        clk_rst = 1'b0;
        repeat (10 * 2 * H) @(negedge clk_in);
        #1;
        check("idle_valids", valid_cnt, 0);
        check("idle_cs_n", {31'd0, cs_n}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // 2: basic frame and latency
        adc_next = 16'h0A5C;
        enable   = 1'b1;
        wait_valid("f1", lat);
        check("f1_sample", {20'd0, sample}, 32'h0A5C);
        check("f1_err", {31'd0, frame_err}, 32'd0);
        check("f1_latency", lat, 2202);
        check("f1_cs_n", {31'd0, cs_n}, 32'd1);
        adc_next = 16'h8123;
        @(negedge clk_in);
        #1;
        check("f1_valid_drop", {31'd0, sample_valid}, 32'd0);
        check("f1_count", valid_cnt, 1);

        // 3: non-zero leading bits flag a frame error
        wait_valid("f2", lat);
        check("f2_sample", {20'd0, sample}, 32'h0123);
        check("f2_err", {31'd0, frame_err}, 32'd1);
        check("f2_latency", lat, 2202);
        check("f2_count", valid_cnt, 2);
        adc_next = 16'h0001;

        // 4: back-to-back frames and the quiet gap between them
        wait_valid("f3", lat);
        check("f3_sample", {20'd0, sample}, 32'h0001);
        check("f3_err", {31'd0, frame_err}, 32'd0);
        adc_next = 16'h0FFF;
        wait_valid("f4", lat);
        check("f4_sample", {20'd0, sample}, 32'h0FFF);
        check("f4_err", {31'd0, frame_err}, 32'd0);
        check("f4_latency", lat, 2202);
        check("gap_sclk_falls", last_falls, 2);
        check("gap_cycles", last_high, 212);
        check("f4_count", valid_cnt, 4);
        adc_next = 16'h0456;

        // 5: enable dropped mid-frame; the frame still completes, then idle
        wait_cs_fall("f5_start");
        repeat (8 * 2 * H) @(negedge clk_in);
        #1;
        enable = 1'b0;
        check("f5_busy_mid", {31'd0, busy}, 32'd1);
        wait_valid("f5", lat);
        check("f5_sample", {20'd0, sample}, 32'h0456);
        check("f5_latency", lat, 2202);
        repeat (800) @(negedge clk_in);
        #1;
        check("f5_count", valid_cnt, 5);
        check("f5_cs_n", {31'd0, cs_n}, 32'd1);
        check("f5_busy", {31'd0, busy}, 32'd0);

        // 6: reset mid-frame discards the partial frame
        adc_next = 16'h0777;
        enable   = 1'b1;
        wait_cs_fall("f6_start");
        repeat (5 * 2 * H) @(negedge clk_in);
        #1;
        vc = valid_cnt;
        clk_rst = 1'b1;
        #1;
        check("f6_rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("f6_rst_busy", {31'd0, busy}, 32'd0);
        check("f6_rst_sample", {20'd0, sample}, 32'd0);
        repeat (4) @(negedge clk_in);
        #1;
        adc_next = 16'h0123;
        clk_rst  = 1'b0;
        check("f6_no_valid", valid_cnt, vc);
        wait_valid("f7", lat);
        check("f7_sample", {20'd0, sample}, 32'h0123);
        check("f7_err", {31'd0, frame_err}, 32'd0);
        check("f7_count", valid_cnt, vc + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
